// File: rtl/gene_seq_tx.sv
`default_nettype none
// =============================================================================
// Module   : gene_seq_tx
// Brief    : Byte FIFO plus 2-bit base unpacker that streams a sequence of
//            seq_len bases on a valid/ready interface with first/last flags.
// Revision : 1.0 - initial release
// =============================================================================
module gene_seq_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic                          start,
    input  logic [LEN_W-1:0]              seq_len,
    output logic [1:0]                    base,
    output logic                          base_valid,
    input  logic                          base_ready,
    output logic                          base_first,
    output logic                          base_last,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int               c_AW    = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]    c_DEPTH = (c_AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [7:0]       r_byte;
    logic [1:0]       r_idx;
    logic             r_loaded;
    logic [LEN_W-1:0] r_remaining;
    logic             r_first_pend;
    logic             w_start_ok;
    logic             w_hs;
    logic             w_last_hs;

    assign w_full     = (r_count == c_DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_push     = wr_valid && !w_full;
    assign wr_ready   = !w_full;
    assign fifo_level = r_count;

    assign w_start_ok = (r_state == c_IDLE) && start && (seq_len != '0);
    assign base_valid = r_loaded && (r_state == c_SEND);
    assign w_hs       = base_valid && base_ready;
    assign w_last_hs  = w_hs && (r_remaining == LEN_W'(1));
    assign base       = r_byte[2*r_idx +: 2];
    assign base_first = base_valid && r_first_pend;
    assign base_last  = base_valid && (r_remaining == LEN_W'(1));
    assign busy       = (r_state != c_IDLE);
    assign done       = (r_state == c_DONE);

    // Refill when empty-handed, or back-to-back on the final base of a byte;
    // the last base of a sequence never pulls in another byte.
    assign w_pop = (r_state == c_SEND) && !w_empty &&
                   (!r_loaded || (w_hs && (r_idx == 2'd3) && !w_last_hs));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_start_ok) w_state_nxt = c_SEND;
            c_SEND:  if (w_last_hs)  w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte       <= '0;
            r_idx        <= '0;
            r_loaded     <= 1'b0;
            r_remaining  <= '0;
            r_first_pend <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_remaining  <= seq_len;
                r_first_pend <= 1'b1;
            end
            if (w_pop) begin
                r_byte   <= r_mem[r_rd_ptr];
                r_idx    <= '0;
                r_loaded <= 1'b1;
            end else if (w_hs) begin
                // Ending mid-byte drops the rest so the next sequence is byte-aligned.
                if (w_last_hs || (r_idx == 2'd3)) begin
                    r_loaded <= 1'b0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            if (w_hs) begin
                r_remaining  <= r_remaining - LEN_W'(1);
                r_first_pend <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/gene_seq_tx.md
# gene_seq_tx

Sequence transmitter that feeds the gene matcher's base-stream input. A host writes packed DNA bytes, four 2-bit bases each, into a small byte FIFO. On `start` the block unpacks exactly `seq_len` bases and presents them one at a time on a valid/ready stream, flagging the first and last base of the sequence. It is the sending end of the matcher's base interface and is used both in the top-level wrapper and as a bench stimulus source.

## Interface
- `FIFO_DEPTH`, default 4: byte FIFO depth; power of two, ≥2.
- `LEN_W`, default 8: width of the sequence-length field.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `wr_data`  in  8  packed bases; base k = `wr_data[2k+1:2k]`, k=0 sent first. Encoding: A=00, C=01, G=10, T=11.
- `wr_valid`  in  1  host write strobe.
- `wr_ready`  out  1  equals `!fifo_full`.
- `start`  in  1  single-cycle request to send a sequence.
- `seq_len`  in  LEN_W  number of bases to send; sampled only when `start` is accepted.
- `base`  out  2  current base.
- `base_valid`  out  1  `base` is valid.
- `base_ready`  in  1  matcher accepts the base.
- `base_first`  out  1  qualifies `base` as the first base of the sequence.
- `base_last`  out  1  qualifies `base` as the last base of the sequence.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse after the last base is accepted.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of bytes currently held in the FIFO.

## Operation
- **FIFO**
  - A push occurs when `wr_valid && wr_ready`. Pushes are allowed in every state.
  - A simultaneous push and pop leaves `fifo_level` unchanged.
  - When full, `wr_ready=0`. There is no same-cycle pass-through.
- **Unpacker**
  - Holds a byte register, a 2-bit base index `idx`, and a `loaded` flag.
  - `base = byte[2*idx+1:2*idx]`.
  - `base_valid = loaded && state==SEND`.
- **IDLE**
  - On `start` with `seq_len != 0`: latch `remaining = seq_len`, set `first_pend=1`, go to SEND.
  - `start` with `seq_len == 0` is ignored: no `done` pulse.
  - `start` is ignored in every state other than IDLE.
- **SEND**
  - If `!loaded` and the FIFO is not empty: pop a byte, set `idx=0`, set `loaded=1`.
  - A handshake is `base_valid && base_ready`. On each handshake:
    - `remaining` decrements;
    - `first_pend` clears.
  - On a handshake with `idx==3` and the FIFO not empty, the next byte is popped in the same cycle, so there is no bubble. With `idx==3` and the FIFO empty, `loaded` clears.
  - Otherwise a handshake increments `idx`.
  - `base_first = base_valid && first_pend`.
  - `base_last = base_valid && remaining==1`.
  - On the handshake with `remaining==1`:
    - clear `loaded`, discarding any unsent bases of the current byte; every sequence starts byte-aligned;
    - do not pop a byte;
    - go to DONE.
- **DONE**
  - `done=1` for one cycle, then go to IDLE.
- **`busy`**
  - 1 in SEND and DONE.
- **FIFO underrun in SEND**
  - `base_valid` stays low until a byte arrives; this is not an error.
- **`rst`**
  - Returns to IDLE from any state and empties the FIFO.
  - Reset values: `wr_ready=1`; `base_valid`, `base_first`, `base_last`, `busy`, `done` = 0; `base=0`; `fifo_level=0`.

## Timing
- `start` accepted at cycle t:
  - `busy=1` at t+1.
  - If the FIFO is non-empty, the pop occurs at t+1 and the first `base_valid` at t+2.
- Sustained throughput is 1 base/cycle while `base_ready=1` and the FIFO is not starved.
- `base`, `base_first` and `base_last` hold stable while `base_valid && !base_ready`.
- The last handshake at cycle n gives `done=1` at n+1 and IDLE at n+2.
- `start` is honoured in IDLE only, so the earliest new `start` is at n+2.
- A push at cycle t is visible in `fifo_level` at t+1.

## Test plan
1. **Reset.** Assert `rst` for 2 cycles → `wr_ready=1`, `fifo_level=0`, `base_valid=0`, `busy=0`, `done=0`.
2. **Single byte.** Push 0xE4, `start` with `seq_len=4`, `base_ready=1` held → `base` = 0,1,2,3 on 4 consecutive cycles. `base_first` on the first base, `base_last` on the fourth, `done` on the next cycle.
3. **Partial byte.** Push 0x1B then 0xFF, `seq_len=6` → bases 3,2,1,0,3,3. The last two bases of 0xFF are dropped and `fifo_level=0` at the end. A following `start` with `seq_len=1` after pushing 0x02 → base 2.
4. **Backpressure.** 8 bases from 0xE4 and 0xE4, with `base_ready` pattern 1,0,0,1,1,0,1… → `base` stays stable while stalled. Exactly 8 handshakes, in order 0,1,2,3,0,1,2,3.
5. **FIFO full and no-op start.** With `FIFO_DEPTH=4`, push 5 bytes → `wr_ready=0` after the 4th push and `fifo_level=4`. `start` with `seq_len=0` → no `busy`, no `done`.
6. **Reset mid-sequence.** `rst` asserted during SEND after 2 bases → next cycle `busy=0`, `base_valid=0`, `fifo_level=0`. A fresh push plus `start` then sends correctly from base 0.
